ram_access_ctrl: RTL
====================

// Module: ram_access_ctrl
// PURPOSE
//  Memory stage between control unit and datapath bus: owns the 32-bit word RAM, serves RAMread/RAMwrite.
//  Address comes from MAR, write data from MDR; read data returns as Mdatain into MDR's memory input.
//  Models wait-state latency; one-cycle mem_done tells the control unit to advance its T-step.
// PARAMETERS
//  ADDR_W       9    address width (MAR low bits used)
//  DEPTH        512  implemented words; must be <= 2**ADDR_W
//  WAIT_STATES  2    extra cycles between request capture and RAM access (0..15)
//  INIT_FILE    ""   $readmemh image loaded at time 0 when non-empty
// PORTS
//  clk        in   1       system clock, rising edge
//  clr        in   1       asynchronous active-high reset
//  RAMread    in   1       read request (level; acted on at rising edge only)
//  RAMwrite   in   1       write request (level; acted on at rising edge only)
//  MARout     in   ADDR_W  word address
//  MDRout     in   32      write data
//  err_clr    in   1       synchronous clear of mem_err
//  Mdatain    out  32      read data to MDR; held until next successful read
//  mem_busy   out  1       high from capture edge until the access edge
//  mem_done   out  1       one-cycle pulse on access completion
//  mem_err    out  1       sticky protocol/range error
// BEHAVIOUR
//  Reset (clr=1, async): state IDLE, Mdatain=0, mem_busy=0, mem_done=0, mem_err=0, request-history regs=0.
//   RAM contents are NOT cleared by clr.
//  Request detect: rd_rise = RAMread & ~RAMread_q; wr_rise likewise; _q regs updated every edge.
//  FSM IDLE -> WAIT -> ACCESS -> IDLE:
//   IDLE: on an edge with exactly one rise, latch op/addr/data, mem_busy<=1; go to WAIT (cnt<=WAIT_STATES),
//         or straight to ACCESS when WAIT_STATES=0.
//   WAIT: cnt decrements each edge; at cnt==1 go to ACCESS.
//   ACCESS: at this edge perform op on latched addr; read loads Mdatain; mem_done<=1, mem_busy<=0; -> IDLE.
//  mem_done is high exactly one cycle, then cleared on the next edge.
//  Latency: request rises before edge E0 -> access at edge E0+1+WAIT_STATES; mem_done high for the cycle after.
//  Inputs are latched at E0; MARout/MDRout changes after E0 do not affect the access.
//  Level held high across/after completion produces no repeat access (edge-triggered).
//  Boundary cases:
//   - rd_rise & wr_rise same edge in IDLE: no access, mem_err<=1, Mdatain unchanged, no mem_done.
//   - rise while not IDLE: ignored (not queued), mem_err<=1; current access completes normally.
//   - latched addr >= DEPTH: no write / read returns 0 into Mdatain; mem_done still pulses, mem_err<=1.
//   - err_clr and new error on same edge: error wins (mem_err stays 1).
//   - clr before ACCESS edge: access aborted, RAM untouched; clr at ACCESS edge: write suppressed.
//  Synthesizable RAM: synchronous write, registered read; no combinational path input->output.
// TESTING
//  1 clr=1 mid-sim -> all outputs 0 immediately (async); after release mem_busy=0, no mem_done.
//  2 WAIT_STATES=2: write 0x12345678 @0x005 -> mem_busy 3 cycles, one mem_done; read @0x005 -> Mdatain=0x12345678 with mem_done.
//  3 RAMread and RAMwrite rise same edge -> no mem_done, mem_err=1, Mdatain unchanged; err_clr pulse -> mem_err=0.
//  4 DEPTH=256 instance: write 0xDEADBEEF @0x100, read @0x100 -> Mdatain=0, mem_err=1; addr 0x0FF unaffected.
//  5 write 0xAAAA5555 over 0x11111111 @0x010, assert clr during WAIT -> readback @0x010 = 0x11111111.
//  6 RAMread held high 10 cycles; second read rise during busy -> exactly one mem_done, mem_err=1.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Memory stage between the control unit and the datapath bus: word RAM with
// edge-triggered read/write requests, programmable wait states and a done pulse.
module ram_access_ctrl #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              RAMread,
    input  logic              RAMwrite,
    input  logic [ADDR_W-1:0] MARout,
    input  logic [31:0]       MDRout,
    input  logic              err_clr,
    output logic [31:0]       Mdatain,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic              rd_q;
    logic              wr_q;
    logic              rd_rise;
    logic              wr_rise;
    logic [CNT_W-1:0]  cnt;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic              capture;
    logic              err_set;
    logic              do_read;
    logic              do_write;
    logic              busy_d;
    logic              done_d;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_rise  = RAMread & ~rd_q;
    assign wr_rise  = RAMwrite & ~wr_q;
    assign in_range = {1'b0, addr_q} < DEPTH_L;
    assign idx      = addr_q[IDX_W-1:0];

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (rd_rise ^ wr_rise) begin
                    next_state = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = S_ACCESS;
                end
            end
            S_ACCESS: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Per-edge controls; simultaneous rises in IDLE are rejected as ambiguous.
    always_comb begin
        capture  = 1'b0;
        err_set  = 1'b0;
        do_read  = 1'b0;
        do_write = 1'b0;
        busy_d   = (next_state != S_IDLE);
        done_d   = 1'b0;
        case (state)
            S_IDLE: begin
                capture = rd_rise ^ wr_rise;
                err_set = rd_rise & wr_rise;
            end
            S_WAIT: begin
                err_set = rd_rise | wr_rise;
            end
            S_ACCESS: begin
                err_set  = rd_rise | wr_rise | ~in_range;
                do_read  = ~op_wr_q;
                do_write = op_wr_q & in_range;
                done_d   = 1'b1;
            end
            default: begin
                err_set = 1'b0;
            end
        endcase
    end

    // Request history, latched operands and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt      <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            Mdatain  <= '0;
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            rd_q     <= RAMread;
            wr_q     <= RAMwrite;
            mem_busy <= busy_d;
            mem_done <= done_d;
            if (capture) begin
                cnt     <= CNT_W'(WAIT_STATES);
                op_wr_q <= wr_rise;
                addr_q  <= MARout;
                data_q  <= MDRout;
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_read) begin
                Mdatain <= in_range ? mem[idx] : '0;
            end
            if (err_set) begin
                mem_err <= 1'b1;
            end else if (err_clr) begin
                mem_err <= 1'b0;
            end
        end
    end

    // Synchronous write port; a clr coinciding with the access edge suppresses it.
    always_ff @(posedge clk) begin
        if (do_write && !clr) begin
            mem[idx] <= data_q;
        end
    end

endmodule
